// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MIPS-style multiply/divide unit that owns HI/LO.
//   clk            : clock, rising edge
//   rst            : synchronous active-high reset
//   start, op      : begin MULT(00)/MULTU(01)/DIV(10)/DIVU(11) on rs_val, rt_val
//   hilo_read      : MFHI/MFLO in the read stage (stalls while busy)
//   mthi, mtlo     : write wdata into HI / LO (IDLE only)
//   hi, lo         : architectural HI/LO
//   busy           : operation in progress (CALC or FIXUP)
//   mult_div_stall : combinational stall request to the pipeline
//   done           : one-cycle pulse when HI/LO first show a new result
//
// state | meaning
// IDLE  | HI/LO stable, accepts start or MTHI/MTLO
// CALC  | 32 shift-add / restoring-divide iterations, counter 0..31
// FIXUP | sign correction, HI/LO written on exit
module mult_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        hilo_read,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        mult_div_stall,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        neg_a_q, neg_a_d;
  logic        neg_b_q, neg_b_d;
  logic        divz_q, divz_d;
  logic [31:0] opnd_q, opnd_d;   // |multiplicand| or |divisor|
  logic [63:0] acc_q, acc_d;     // mult: {partial, multiplier}; div: {rem, dividend/quotient}
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        done_q, done_d;

  logic [31:0] rs_abs, rt_abs;
  logic [32:0] mul_sum, div_shift, div_diff;
  logic        div_ok;
  logic [63:0] mul_next, div_next, prod_fix;
  logic [31:0] quo_fix, rem_fix;

  // Only signed ops (op[0]==0) take absolute values.
  assign rs_abs = (~op[0] & rs_val[31]) ? (~rs_val + 32'd1) : rs_val;
  assign rt_abs = (~op[0] & rt_val[31]) ? (~rt_val + 32'd1) : rt_val;

  // Radix-2 shift-add: add multiplicand into the top half when the
  // current multiplier bit is set, then shift the whole 65-bit value right.
  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign mul_next = {mul_sum, acc_q[31:1]};

  // Restoring divide: a set bit 32 of the difference means the trial
  // subtraction went negative and the shifted remainder is kept.
  assign div_shift = {acc_q[63:32], acc_q[31]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_ok    = ~div_diff[32];
  assign div_next  = {(div_ok ? div_diff[31:0] : div_shift[31:0]), acc_q[30:0], div_ok};

  // With a zero divisor the iterations leave rem=|dividend|, so the
  // remainder sign fix restores rs_val; only the quotient is forced.
  assign prod_fix = (neg_a_q ^ neg_b_q) ? (~acc_q + 64'd1) : acc_q;
  assign quo_fix  = divz_q ? 32'hFFFF_FFFF :
                    (neg_a_q ^ neg_b_q) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
  assign rem_fix  = neg_a_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    divz_d   = divz_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_CALC;
          cnt_d    = 5'd0;
          is_div_d = op[1];
          neg_a_d  = ~op[0] & rs_val[31];
          neg_b_d  = ~op[0] & rt_val[31];
          divz_d   = op[1] & (rt_val == 32'd0);
          opnd_d   = op[1] ? rt_abs : rs_abs;
          acc_d    = op[1] ? {32'd0, rs_abs} : {32'd0, rt_abs};
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      S_CALC: begin
        acc_d = is_div_q ? div_next : mul_next;
        if (cnt_q == 5'd31) state_d = S_FIXUP;
        else                cnt_d   = cnt_q + 5'd1;
      end
      S_FIXUP: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      divz_q   <= 1'b0;
      opnd_q   <= 32'd0;
      acc_q    <= 64'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      divz_q   <= divz_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign hi             = hi_q;
  assign lo             = lo_q;
  assign busy           = (state_q != S_IDLE);
  assign done           = done_q;
  assign mult_div_stall = busy & (start | hilo_read | mthi | mtlo);

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors for mult_div_unit plus sequences for
// stall, MTHI/MTLO interaction and reset corner cases.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst, start, hilo_read, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val, wdata;
  logic [31:0] hi, lo;
  logic        busy, mult_div_stall, done;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] mdl_hi, mdl_lo;

  always #5 clk = ~clk;

  mult_div_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .hilo_read(hilo_read), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .mult_div_stall(mult_div_stall), .done(done)
  );

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Run one operation from the start edge to done; checks latency, busy
  // length, HI/LO hold during the operation, the result and the pulse width.
  task automatic run_op(input vec_t v);
    int cycles = 0;
    int busy_cnt = 0;
    bit held_ok = 1'b1;
    op = v.op; rs_val = v.rs; rt_val = v.rt; start = 1'b1;
    tick();
    start = 1'b0;
    while (!done && cycles < 100) begin
      if (busy) busy_cnt++;
      if (hi !== mdl_hi || lo !== mdl_lo) held_ok = 1'b0;
      tick();
      cycles++;
    end
    check({v.name, " latency"}, 64'(cycles), 64'd33);
    check({v.name, " busy cycles"}, 64'(busy_cnt), 64'd33);
    check({v.name, " hilo held"}, 64'(held_ok), 64'd1);
    check({v.name, " hi"}, 64'(hi), 64'(v.exp_hi));
    check({v.name, " lo"}, 64'(lo), 64'(v.exp_lo));
    check({v.name, " busy at done"}, 64'(busy), 64'd0);
    mdl_hi = v.exp_hi; mdl_lo = v.exp_lo;
    tick();
    check({v.name, " done pulse width"}, 64'(done), 64'd0);
  endtask

  initial begin
    int k;
    bit stall_ok;
    bit no_done;
    vecs[0]  = '{"multu max",     2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{"mult -3x5",     2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2]  = '{"div -7/2",      2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{"divu 100/0",    2'b11, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
    vecs[4]  = '{"div min/-1",    2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{"div -100/0",    2'b10, 32'hFFFFFF9C, 32'h00000000, 32'hFFFFFF9C, 32'hFFFFFFFF};
    vecs[6]  = '{"mult min*min",  2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[7]  = '{"multu x*0",     2'b01, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000};
    vecs[8]  = '{"div 7/-2",      2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[9]  = '{"divu max/16",   2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
    vecs[10] = '{"mult 7*-1",     2'b00, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};
    vecs[11] = '{"div -7/-2",     2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};
    vecs[12] = '{"multu 2^16sq",  2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};

    rst = 1'b1; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
    hilo_read = 1'b0; mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    tick(); tick();
    rst = 1'b0;
    mdl_hi = 32'd0; mdl_lo = 32'd0;
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);

    // MTLO / MTHI in IDLE
    wdata = 32'hCAFEF00D; mtlo = 1'b1; tick(); mtlo = 1'b0;
    check("mtlo idle", 64'(lo), 64'hCAFEF00D);
    wdata = 32'h11112222; mthi = 1'b1; tick(); mthi = 1'b0;
    check("mthi idle", 64'(hi), 64'h11112222);
    mdl_hi = 32'h11112222; mdl_lo = 32'hCAFEF00D;

    for (int i = 0; i < 13; i++) run_op(vecs[i]);

    // hilo_read held through the operation: stall every busy cycle, old values visible
    op = 2'b01; rs_val = 32'h00000003; rt_val = 32'h00000007; start = 1'b1;
    tick();
    start = 1'b0; hilo_read = 1'b1;
    stall_ok = 1'b1;
    for (int i = 0; i < 33; i++) begin
      if (mult_div_stall !== 1'b1 || hi !== mdl_hi || lo !== mdl_lo) stall_ok = 1'b0;
      tick();
    end
    check("stall during busy", 64'(stall_ok), 64'd1);
    check("stall seq done", 64'(done), 64'd1);
    check("stall released idle", 64'(mult_div_stall), 64'd0);
    check("stall seq lo", 64'(lo), 64'd21);
    hilo_read = 1'b0;
    mdl_hi = 32'd0; mdl_lo = 32'd21;
    tick();

    // MTHI while busy has no effect
    op = 2'b11; rs_val = 32'd50; rt_val = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    wdata = 32'h12345678; mthi = 1'b1;
    tick();
    mthi = 1'b0;
    check("mthi busy ignored", 64'(hi), 64'(mdl_hi));
    k = 0;
    while (!done && k < 100) begin tick(); k++; end
    check("divu 50/7 lo", 64'(lo), 64'd7);
    check("divu 50/7 hi", 64'(hi), 64'd1);
    mdl_hi = 32'd1; mdl_lo = 32'd7;
    tick();

    // start and MTLO together in IDLE: start wins
    op = 2'b01; rs_val = 32'd6; rt_val = 32'd9; start = 1'b1;
    wdata = 32'hDEADBEEF; mtlo = 1'b1;
    tick();
    start = 1'b0; mtlo = 1'b0;
    check("start+mtlo lo kept", 64'(lo), 64'(mdl_lo));
    check("start+mtlo busy", 64'(busy), 64'd1);
    k = 0;
    while (!done && k < 100) begin tick(); k++; end
    check("start+mtlo result", 64'(lo), 64'd54);
    mdl_hi = 32'd0; mdl_lo = 32'd54;
    tick();

    // Reset at CALC iteration 10 aborts with no write and no done
    op = 2'b01; rs_val = 32'hFFFFFFFF; rt_val = 32'h2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("busy before abort", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", 64'(busy), 64'd0);
    check("abort hi", 64'(hi), 64'd0);
    check("abort lo", 64'(lo), 64'd0);
    mdl_hi = 32'd0; mdl_lo = 32'd0;
    no_done = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) no_done = 1'b0;
      tick();
    end
    check("abort no done", 64'(no_done), 64'd1);
    run_op(vecs[1]);

    // Reset beats start and MTLO in the same cycle
    rst = 1'b1; start = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5A5A5;
    tick();
    rst = 1'b0; start = 1'b0; mtlo = 1'b0;
    check("rst prio busy", 64'(busy), 64'd0);
    check("rst prio lo", 64'(lo), 64'd0);
    check("rst prio hi", 64'(hi), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
